// File: rtl/pyramid_scheduler_if.sv
// Handshake bundle between pyramid_scheduler, the HLS face-detect core, the
// frame receiver and the result queue. master = scheduler side, slave = environment.
interface pyramid_scheduler_if #(
    parameter int unsigned LEVEL_W = 4,
    parameter int unsigned COUNT_W = 32
) ();

    // Frame receiver / core status
    logic               frame_ready;
    logic               ap_idle;
    logic               ap_ready;
    logic               ap_done;
    logic [COUNT_W-1:0] ap_return;
    // Core control
    logic               ap_start;
    logic [LEVEL_W-1:0] level;
    // Result queue
    logic               result_valid;
    logic               result_ready;
    logic [LEVEL_W-1:0] result_level;
    logic [COUNT_W-1:0] result_count;
    // Status
    logic [COUNT_W-1:0] total_faces;
    logic               busy;
    logic               pipeline_done;
    logic               frame_dropped;
    logic               timeout_err;

    modport master (
        input  frame_ready, ap_idle, ap_ready, ap_done, ap_return, result_ready,
        output ap_start, level, result_valid, result_level, result_count,
               total_faces, busy, pipeline_done, frame_dropped, timeout_err
    );

    modport slave (
        output frame_ready, ap_idle, ap_ready, ap_done, ap_return, result_ready,
        input  ap_start, level, result_valid, result_level, result_count,
               total_faces, busy, pipeline_done, frame_dropped, timeout_err
    );

endinterface

// File: rtl/pyramid_scheduler.sv
// Pyramid scheduler: runs the face-detect core once per pyramid level of a received
// frame, emits one (level, count) beat per level and keeps a saturating face total.
// Optional watchdog: define PYRAMID_SCHEDULER_WATCHDOG_EN to abort a frame when one
// level spends TIMEOUT_CYCLES cycles in START/RUN.
module pyramid_scheduler #(
    parameter int unsigned NUM_LEVELS     = 10,
    parameter int unsigned LEVEL_W        = 4,
    parameter int unsigned COUNT_W        = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16777216
) (
    input  logic                clock,
    input  logic                reset,
    pyramid_scheduler_if.master sched_io
);

    if (NUM_LEVELS < 1 || NUM_LEVELS > (1 << LEVEL_W) || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("pyramid_scheduler: illegal NUM_LEVELS/LEVEL_W/TIMEOUT_CYCLES");
    end

    typedef enum logic [2:0] {StIdle, StStart, StRun, StReport, StDone} state_e;

    localparam logic [LEVEL_W-1:0] LastLevel = LEVEL_W'(NUM_LEVELS - 1);

    state_e state_q, state_d;

    logic               ap_start_q, ap_start_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               result_valid_q, result_valid_d;
    logic [LEVEL_W-1:0] result_level_q, result_level_d;
    logic [COUNT_W-1:0] result_count_q, result_count_d;
    logic [COUNT_W-1:0] total_q, total_d;
    logic               busy_q, busy_d;
    logic               pipeline_done_q, pipeline_done_d;
    logic               frame_dropped_q, frame_dropped_d;

    logic               accept_frame;
    logic               capture;
    logic               beat_accept;
    logic               last_level;
    logic               wd_abort;
    logic [COUNT_W:0]   sum_wide;
    logic [COUNT_W-1:0] sum_sat;

    assign accept_frame = (state_q == StIdle) && sched_io.frame_ready && sched_io.ap_idle;
    // A level result is taken either with the start acknowledge or later in RUN
    assign capture      = ((state_q == StStart) && sched_io.ap_ready && sched_io.ap_done) ||
                          ((state_q == StRun) && sched_io.ap_done);
    assign beat_accept  = (state_q == StReport) && sched_io.result_ready;
    assign last_level   = (level_q == LastLevel);

    assign sum_wide = {1'b0, total_q} + {1'b0, sched_io.ap_return};
    assign sum_sat  = sum_wide[COUNT_W] ? {COUNT_W{1'b1}} : sum_wide[COUNT_W-1:0];

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a real completion wins over a simultaneous watchdog expiry
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept_frame) state_d = StStart;
            end
            StStart: begin
                if (capture)                  state_d = StReport;
                else if (wd_abort)            state_d = StDone;
                else if (sched_io.ap_ready)   state_d = StRun;
            end
            StRun: begin
                if (capture)       state_d = StReport;
                else if (wd_abort) state_d = StDone;
            end
            StReport: begin
                if (sched_io.result_ready) state_d = last_level ? StDone : StStart;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Next values of the registered outputs, derived from the upcoming state
    always_comb begin
        ap_start_d      = (state_d == StStart);
        busy_d          = (state_d inside {StStart, StRun, StReport});
        result_valid_d  = (state_d == StReport);
        pipeline_done_d = (state_d == StDone);
        frame_dropped_d = sched_io.frame_ready && !accept_frame;
        level_d         = level_q;
        result_level_d  = result_level_q;
        result_count_d  = result_count_q;
        total_d         = total_q;
        if (accept_frame) begin
            level_d = '0;
            total_d = '0;
        end
        if (capture) begin
            result_level_d = level_q;
            result_count_d = sched_io.ap_return;
            total_d        = sum_sat;
        end
        if (beat_accept && !last_level) begin
            level_d = level_q + 1'b1;
        end
    end

    // Output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ap_start_q      <= 1'b0;
            level_q         <= '0;
            result_valid_q  <= 1'b0;
            result_level_q  <= '0;
            result_count_q  <= '0;
            total_q         <= '0;
            busy_q          <= 1'b0;
            pipeline_done_q <= 1'b0;
            frame_dropped_q <= 1'b0;
        end else begin
            ap_start_q      <= ap_start_d;
            level_q         <= level_d;
            result_valid_q  <= result_valid_d;
            result_level_q  <= result_level_d;
            result_count_q  <= result_count_d;
            total_q         <= total_d;
            busy_q          <= busy_d;
            pipeline_done_q <= pipeline_done_d;
            frame_dropped_q <= frame_dropped_d;
        end
    end

`ifdef PYRAMID_SCHEDULER_WATCHDOG_EN
    localparam int unsigned WdW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
    logic           timeout_err_q, timeout_err_d;

    // Fires on the TIMEOUT_CYCLES-th cycle spent in START/RUN for the current level
    assign wd_abort = (state_q inside {StStart, StRun}) && !capture &&
                      (wd_cnt_q == WdW'(TIMEOUT_CYCLES - 1));

    // Watchdog counter and sticky error next-state
    always_comb begin
        wd_cnt_d      = wd_cnt_q;
        timeout_err_d = timeout_err_q;
        if ((state_d == StStart) && (state_q != StStart)) begin
            wd_cnt_d = '0;
        end else if (state_q inside {StStart, StRun}) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
        if (accept_frame) timeout_err_d = 1'b0;
        if (wd_abort)     timeout_err_d = 1'b1;
    end

    // Watchdog registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign sched_io.timeout_err = timeout_err_q;
`else
    assign wd_abort             = 1'b0;
    assign sched_io.timeout_err = 1'b0;
`endif

    assign sched_io.ap_start      = ap_start_q;
    assign sched_io.level         = level_q;
    assign sched_io.result_valid  = result_valid_q;
    assign sched_io.result_level  = result_level_q;
    assign sched_io.result_count  = result_count_q;
    assign sched_io.total_faces   = total_q;
    assign sched_io.busy          = busy_q;
    assign sched_io.pipeline_done = pipeline_done_q;
    assign sched_io.frame_dropped = frame_dropped_q;

endmodule

// File: tb/tb_pyramid_scheduler.sv
// Directed bench for pyramid_scheduler with NUM_LEVELS=3 and TIMEOUT_CYCLES=100.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_pyramid_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clock = ~clock;

    pyramid_scheduler_if #(.LEVEL_W(4), .COUNT_W(32)) sched_bus ();

    pyramid_scheduler #(
        .NUM_LEVELS    (3),
        .LEVEL_W       (4),
        .COUNT_W       (32),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .sched_io(sched_bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic pulse_frame();
        sched_bus.frame_ready = 1'b1;
        tick();
        sched_bus.frame_ready = 1'b0;
    endtask

    // Entered in START; leaves at the first REPORT cycle with the beat checked.
    task automatic run_level(input logic [3:0] lvl, input logic [31:0] ret,
                             input logic [31:0] exp_total, input bit same_cycle,
                             input bit poke_frame);
        check_eq("start_req", 32'(sched_bus.ap_start), 1);
        check_eq("core_level", 32'(sched_bus.level), 32'(lvl));
        sched_bus.ap_ready = 1'b1;
        if (same_cycle) begin
            sched_bus.ap_done   = 1'b1;
            sched_bus.ap_return = ret;
            tick();
            sched_bus.ap_ready = 1'b0;
            sched_bus.ap_done  = 1'b0;
            check_eq("single_start", 32'(sched_bus.ap_start), 0);
        end else begin
            tick();
            sched_bus.ap_ready = 1'b0;
            check_eq("start_drop", 32'(sched_bus.ap_start), 0);
            sched_bus.frame_ready = poke_frame;
            tick();
            sched_bus.frame_ready = 1'b0;
            if (poke_frame) check_eq("drop_in_run", 32'(sched_bus.frame_dropped), 1);
            sched_bus.ap_done   = 1'b1;
            sched_bus.ap_return = ret;
            tick();
            sched_bus.ap_done = 1'b0;
            if (poke_frame) check_eq("drop_one_cycle", 32'(sched_bus.frame_dropped), 0);
        end
        sched_bus.ap_return = 32'hDEAD_BEEF;
        check_eq("beat_valid", 32'(sched_bus.result_valid), 1);
        check_eq("beat_level", 32'(sched_bus.result_level), 32'(lvl));
        check_eq("beat_count", sched_bus.result_count, ret);
        check_eq("total", sched_bus.total_faces, exp_total);
    endtask

    // Called in the last REPORT cycle with result_ready high.
    task automatic finish_frame(input logic [31:0] exp_total);
        tick();
        check_eq("done_pulse", 32'(sched_bus.pipeline_done), 1);
        check_eq("busy_fall", 32'(sched_bus.busy), 0);
        check_eq("valid_fall", 32'(sched_bus.result_valid), 0);
        check_eq("done_total", sched_bus.total_faces, exp_total);
        tick();
        check_eq("done_once", 32'(sched_bus.pipeline_done), 0);
        check_eq("total_hold", sched_bus.total_faces, exp_total);
    endtask

    initial begin
        #200000;
        $display("FAIL tb_timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        bit saw_done;
        bit lost_start;
        reset                  = 1'b1;
        sched_bus.frame_ready  = 1'b0;
        sched_bus.ap_idle      = 1'b1;
        sched_bus.ap_ready     = 1'b0;
        sched_bus.ap_done      = 1'b0;
        sched_bus.ap_return    = '0;
        sched_bus.result_ready = 1'b1;
        repeat (2) tick();

        check_eq("rst_ap_start", 32'(sched_bus.ap_start), 0);
        check_eq("rst_busy", 32'(sched_bus.busy), 0);
        check_eq("rst_valid", 32'(sched_bus.result_valid), 0);
        check_eq("rst_level", 32'(sched_bus.level), 0);
        check_eq("rst_count", sched_bus.result_count, 0);
        check_eq("rst_total", sched_bus.total_faces, 0);
        check_eq("rst_done", 32'(sched_bus.pipeline_done), 0);
        check_eq("rst_dropped", 32'(sched_bus.frame_dropped), 0);
        check_eq("rst_timeout", 32'(sched_bus.timeout_err), 0);
        reset = 1'b0;
        tick();

        // Core not idle: frame must be refused
        sched_bus.ap_idle = 1'b0;
        pulse_frame();
        check_eq("drop_not_idle", 32'(sched_bus.frame_dropped), 1);
        check_eq("no_busy_not_idle", 32'(sched_bus.busy), 0);
        check_eq("no_start_not_idle", 32'(sched_bus.ap_start), 0);
        sched_bus.ap_idle = 1'b1;
        tick();
        check_eq("drop_clear", 32'(sched_bus.frame_dropped), 0);

        // Frame A: returns 2,0,5
        pulse_frame();
        check_eq("busy_rise", 32'(sched_bus.busy), 1);
        run_level(4'd0, 32'd2, 32'd2, 1'b0, 1'b0);
        tick();
        run_level(4'd1, 32'd0, 32'd2, 1'b0, 1'b0);
        tick();
        run_level(4'd2, 32'd5, 32'd7, 1'b0, 1'b0);
        finish_frame(32'd7);

        // Frame B: frame_ready during RUN, stalled beat at level 1, saturation
        pulse_frame();
        check_eq("total_clear", sched_bus.total_faces, 0);
        run_level(4'd0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 1'b0, 1'b1);
        tick();
        sched_bus.result_ready = 1'b0;
        run_level(4'd1, 32'h0000_0020, 32'hFFFF_FFFF, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("stall_valid", 32'(sched_bus.result_valid), 1);
            check_eq("stall_count", sched_bus.result_count, 32'h20);
            check_eq("stall_no_start", 32'(sched_bus.ap_start), 0);
        end
        sched_bus.result_ready = 1'b1;
        tick();
        check_eq("accept_valid_fall", 32'(sched_bus.result_valid), 0);
        run_level(4'd2, 32'd3, 32'hFFFF_FFFF, 1'b0, 1'b0);
        finish_frame(32'hFFFF_FFFF);

        // Frame C: ap_ready and ap_done together with ap_start
        pulse_frame();
        run_level(4'd0, 32'd4, 32'd4, 1'b1, 1'b0);
        tick();
        run_level(4'd1, 32'd1, 32'd5, 1'b0, 1'b0);
        tick();
        run_level(4'd2, 32'd1, 32'd6, 1'b1, 1'b0);
        finish_frame(32'd6);

        // Frame D: reset while the core runs level 1
        pulse_frame();
        run_level(4'd0, 32'd3, 32'd3, 1'b0, 1'b0);
        tick();
        check_eq("d_start_l1", 32'(sched_bus.ap_start), 1);
        sched_bus.ap_ready = 1'b1;
        tick();
        sched_bus.ap_ready = 1'b0;
        check_eq("d_busy_run", 32'(sched_bus.busy), 1);
        #1 reset = 1'b1;
        #1;
        check_eq("mid_rst_busy", 32'(sched_bus.busy), 0);
        check_eq("mid_rst_level", 32'(sched_bus.level), 0);
        check_eq("mid_rst_count", sched_bus.result_count, 0);
        check_eq("mid_rst_total", sched_bus.total_faces, 0);
        check_eq("mid_rst_start", 32'(sched_bus.ap_start), 0);
        #1 reset = 1'b0;
        tick();
        pulse_frame();
        check_eq("post_rst_start", 32'(sched_bus.ap_start), 1);
        check_eq("post_rst_level", 32'(sched_bus.level), 0);

        // Core never answers from here on
        saw_done   = 1'b0;
        lost_start = 1'b0;
`ifdef PYRAMID_SCHEDULER_WATCHDOG_EN
        for (int i = 0; i < 99; i++) begin
            tick();
            if (sched_bus.pipeline_done) saw_done = 1'b1;
            if (!sched_bus.ap_start) lost_start = 1'b1;
        end
        check_eq("wd_no_early_done", 32'(saw_done), 0);
        check_eq("wd_start_held", 32'(lost_start), 0);
        tick();
        check_eq("wd_done_pulse", 32'(sched_bus.pipeline_done), 1);
        check_eq("wd_err_set", 32'(sched_bus.timeout_err), 1);
        check_eq("wd_start_drop", 32'(sched_bus.ap_start), 0);
        check_eq("wd_busy_fall", 32'(sched_bus.busy), 0);
        check_eq("wd_no_beat", 32'(sched_bus.result_valid), 0);
        tick();
        check_eq("wd_done_once", 32'(sched_bus.pipeline_done), 0);
        check_eq("wd_err_sticky", 32'(sched_bus.timeout_err), 1);
        pulse_frame();
        check_eq("wd_err_clear", 32'(sched_bus.timeout_err), 0);
        check_eq("wd_restart", 32'(sched_bus.ap_start), 1);
`else
        for (int i = 0; i < 150; i++) begin
            tick();
            if (sched_bus.pipeline_done) saw_done = 1'b1;
            if (!sched_bus.ap_start) lost_start = 1'b1;
        end
        check_eq("nowd_no_done", 32'(saw_done), 0);
        check_eq("nowd_start_held", 32'(lost_start), 0);
        check_eq("nowd_busy", 32'(sched_bus.busy), 1);
        check_eq("nowd_err", 32'(sched_bus.timeout_err), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
